// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, clock-channel pattern, alignment
// states and the data-period decode used by the per-channel receiver.
package tmds_pkg;

  localparam logic [9:0] CTL_TOKEN_00     = 10'b1101010100;
  localparam logic [9:0] CTL_TOKEN_01     = 10'b0010101011;
  localparam logic [9:0] CTL_TOKEN_10     = 10'b0101010100;
  localparam logic [9:0] CTL_TOKEN_11     = 10'b1010101011;
  localparam logic [9:0] TMDS_CLK_PATTERN = 10'b1111100000;

  typedef enum logic [1:0] {
    SEARCH,
    SLIP,
    WAIT,
    LOCKED
  } align_state_t;

  // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8).
  function automatic logic [7:0] tmds_data_decode(input logic [9:0] raw);
    logic [7:0] q;
    logic [7:0] d;
    q    = raw[9] ? ~raw[7:0] : raw[7:0];
    d    = '0;
    d[0] = q[0];
    for (int unsigned i = 1; i < 8; i++) begin
      d[i] = raw[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

endpackage

// File: rtl/tmds_align_fsm.sv
// Word-alignment controller: counts control-token runs, issues bitslip pulses
// on search timeout and drops lock after a long absence of control tokens.
module tmds_align_fsm
  import tmds_pkg::*;
#(
  parameter int unsigned SEARCH_TIMEOUT = 4096,
  parameter int unsigned MIN_CTL_RUN    = 64,
  parameter int unsigned SLIP_WAIT      = 16,
  parameter int unsigned LOSS_TIMEOUT   = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic is_ctl,
  output logic locked,
  output logic bitslip
);

  localparam int unsigned TIMER_MAX = (SEARCH_TIMEOUT > SLIP_WAIT) ? SEARCH_TIMEOUT : SLIP_WAIT;
  localparam int unsigned TW = $clog2(TIMER_MAX + 1);
  localparam int unsigned RW = $clog2(MIN_CTL_RUN + 1);
  localparam int unsigned LW = $clog2(LOSS_TIMEOUT + 1);

  localparam logic [TW-1:0] SEARCH_LAST = TW'(SEARCH_TIMEOUT - 1);
  localparam logic [TW-1:0] WAIT_LAST   = TW'(SLIP_WAIT - 1);
  localparam logic [RW-1:0] RUN_MAX     = RW'(MIN_CTL_RUN);
  localparam logic [LW-1:0] LOSS_LAST   = LW'(LOSS_TIMEOUT - 1);

  align_state_t  state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [RW-1:0] ctl_run, ctl_run_nxt, run_step;
  logic [LW-1:0] loss, loss_nxt;
  logic          run_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SEARCH;
      timer   <= '0;
      ctl_run <= '0;
      loss    <= '0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      ctl_run <= ctl_run_nxt;
      loss    <= loss_nxt;
    end
  end

  // Lock is taken on the edge where the run count reaches its target.
  always_comb begin
    run_step = '0;
    if (is_ctl) begin
      run_step = (ctl_run == RUN_MAX) ? ctl_run : ctl_run + 1'b1;
    end
    run_full = (run_step == RUN_MAX);
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    ctl_run_nxt = run_step;
    loss_nxt    = loss;
    case (state)
      SEARCH: begin
        if (run_full) begin
          state_nxt = LOCKED;
          timer_nxt = '0;
          loss_nxt  = '0;
        end else if (timer == SEARCH_LAST) begin
          state_nxt = SLIP;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      SLIP: begin
        state_nxt   = WAIT;
        timer_nxt   = '0;
        ctl_run_nxt = '0;
      end
      WAIT: begin
        ctl_run_nxt = '0;
        if (timer == WAIT_LAST) begin
          state_nxt = SEARCH;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      LOCKED: begin
        if (is_ctl) begin
          loss_nxt = '0;
        end else if (loss == LOSS_LAST) begin
          state_nxt = SEARCH;
          timer_nxt = '0;
          loss_nxt  = '0;
        end else begin
          loss_nxt = loss + 1'b1;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  assign locked  = (state == LOCKED);
  assign bitslip = (state == SLIP);

endmodule

// File: rtl/tmds_decode.sv
// Per-channel TMDS receive decoder: registers the deserialized word, classifies
// and decodes it, and drives the pixel outputs two cycles after tmds_raw.
module tmds_decode
  import tmds_pkg::*;
#(
  parameter int unsigned SEARCH_TIMEOUT = 4096,
  parameter int unsigned MIN_CTL_RUN    = 64,
  parameter int unsigned SLIP_WAIT      = 16,
  parameter int unsigned LOSS_TIMEOUT   = 2000000
) (
  input  logic       pixel_clk,
  input  logic       rst,
  input  logic [9:0] tmds_raw,
  output logic       bitslip,
  output logic       locked,
  output logic       active,
  output logic [1:0] ctl,
  output logic [7:0] pdata
);

  logic [9:0] raw_q;
  logic       is_ctl;
  logic [1:0] tok;
  logic [7:0] data_dec;

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      raw_q <= '0;
    end else begin
      raw_q <= tmds_raw;
    end
  end

  always_comb begin
    is_ctl = 1'b1;
    tok    = 2'b00;
    case (raw_q)
      CTL_TOKEN_00: tok = 2'b00;
      CTL_TOKEN_01: tok = 2'b01;
      CTL_TOKEN_10: tok = 2'b10;
      CTL_TOKEN_11: tok = 2'b11;
      default:      is_ctl = 1'b0;
    endcase
  end

  assign data_dec = tmds_data_decode(raw_q);

  tmds_align_fsm #(
    .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
    .MIN_CTL_RUN   (MIN_CTL_RUN),
    .SLIP_WAIT     (SLIP_WAIT),
    .LOSS_TIMEOUT  (LOSS_TIMEOUT)
  ) u_align (
    .clk    (pixel_clk),
    .rst    (rst),
    .is_ctl (is_ctl),
    .locked (locked),
    .bitslip(bitslip)
  );

  // ctl is left untouched during data words so the last token value persists.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      active <= 1'b0;
      ctl    <= 2'b00;
      pdata  <= '0;
    end else if (!locked) begin
      active <= 1'b0;
      ctl    <= 2'b00;
      pdata  <= '0;
    end else if (is_ctl) begin
      active <= 1'b0;
      ctl    <= tok;
      pdata  <= '0;
    end else begin
      active <= 1'b1;
      pdata  <= data_dec;
    end
  end

endmodule

// File: doc/tmds_decode.md
Name: tmds_decode

Overview:
- Per-channel TMDS receive decoder for the HDMI input path.
- Takes parallel 10-bit words from a 1:10 deserializer and finds word alignment by issuing bitslip pulses back to the deserializer.
- Decodes data periods to 8-bit pixel data and control periods to 2-bit ctl. Reports per-channel lock.
- Three instances (B/G/R) sit between the ISERDES wrappers and the video input timing logic, all clocked by pixel_clk.

Parameters:
- SEARCH_TIMEOUT, 4096: cycles without reaching a lock run before a bitslip is issued.
- MIN_CTL_RUN, 64: consecutive control tokens required to declare lock.
- SLIP_WAIT, 16: settle cycles after each bitslip pulse before searching resumes.
- LOSS_TIMEOUT, 2000000: cycles in LOCKED without any control token before lock is dropped.

Ports:
- pixel_clk  in  1  pixel clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- tmds_raw  in  10  deserialized word; bit 0 is the first bit on the wire.
- bitslip  out  1  one-cycle pulse requesting a 1-bit rotate from the deserializer.
- locked  out  1  alignment established.
- active  out  1  current word is a data-period word (not a control token).
- ctl  out  2  decoded control bits {c1,c0}, held through data periods.
- pdata  out  8  decoded pixel byte.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; the clock is pixel_clk and the reset is rst.
- Reset values: bitslip=0, locked=0, active=0, ctl=2'b00, pdata=8'h00. The FSM returns to SEARCH and all counters clear.
- Stage 1 (registered tmds_raw):
  - Token compare: 10'b1101010100->00, 10'b0010101011->01, 10'b0101010100->10, 10'b1010101011->11. Any match gives is_ctl=1.
  - Data decode: q = raw[9] ? ~raw[7:0] : raw[7:0].
  - d[0] = q[0].
  - d[i] = raw[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]), for i = 1..7.
- Stage 2 (outputs): latency from tmds_raw to outputs is exactly 2 cycles.
  - While locked=1:
    - is_ctl: active=0, ctl=token value, pdata=0.
    - else: active=1, pdata=d, ctl holds its last value.
  - While locked=0: active=0, pdata=0, ctl=00 (decode still runs internally).
- ctl_run counter:
  - Increments on is_ctl and saturates at MIN_CTL_RUN.
  - Clears on any non-token word.
  - The token value need not be constant across the run.
- FSM states:
  - SEARCH: timer counts up. If ctl_run reaches MIN_CTL_RUN -> LOCKED (locked=1 next cycle). Otherwise, when the timer reaches SEARCH_TIMEOUT-1 -> SLIP.
  - SLIP: bitslip=1 for exactly one cycle, then -> WAIT.
  - WAIT: SLIP_WAIT cycles with ctl_run held at 0 and words ignored, then -> SEARCH with timer=0.
  - LOCKED: loss timer clears on every is_ctl. When it reaches LOSS_TIMEOUT-1 -> SEARCH with locked=0 the next cycle. Mid-frame data words never drop lock.
- If the lock condition and SEARCH timeout hit in the same cycle, lock wins and no slip is issued.
- Slips are unbounded: after 10 slips the deserializer has wrapped and searching continues indefinitely.
- bitslip is never asserted outside SLIP. It never asserts on consecutive cycles.
- Spacing between slip pulses is at least SLIP_WAIT+2 cycles.
- rst asserted in any state: the reset values above apply on the next edge. A pending slip pulse is suppressed.
- Counter widths: $clog2(param+1) each; no wrap is allowed before a compare fires.

Decomposition:
- Shared package tmds_pkg holds:
  - the four control-token constants (shared with tmds_encode);
  - TMDS_CLK_PATTERN = 10'b1111100000;
  - the alignment state enum {SEARCH, SLIP, WAIT, LOCKED}.
- Natural sub-module: tmds_align_fsm, containing the FSM, the three counters and bitslip generation. Its inputs are is_ctl, clk and rst; its outputs are locked and bitslip. The decode datapath stays in tmds_decode.

Test Plan:
- Lock at correct alignment: reset, then 100 cycles of 10'b1101010100 then encoded data. Required: locked rises 2 cycles after the 64th token; ctl=00, active=0 during the tokens; no bitslip.
- Wrong alignment: drive 10'b1101010100 rotated by 3 bits, with a bench model rotating by 1 on each bitslip. Required: exactly 7 bitslip pulses, each 4096+16+... cycles apart (≥ SLIP_WAIT+2); then locked=1 and ctl=00.
- Data decode round trip: pdata bytes 00, FF, A5, 3C through a reference tmds_encode model, with ctl=2'b01 in blanking. Required: identical bytes and active=1 two cycles after input; ctl=01 held during data.
- Broken run: 63 tokens, one data word, then 63 tokens. Required: no lock; SEARCH timeout then produces a bitslip.
- Loss of lock: lock, then feed data-only words for 2000000 cycles. Required: locked falls on cycle LOSS_TIMEOUT+1; active=0; pdata=0; search resumes.
- Reset mid-SLIP: assert rst in the SLIP cycle. Required: bitslip=0 on the next edge; all outputs at reset values; FSM in SEARCH.
